// File: rtl/cordic_pkg.sv
// Shared definitions for the bit-serial CORDIC sequencer and its helpers.
//   - state_t : sequencer state encoding
//   - OP_ADD / OP_SUB : adder control encoding seen by the z/x/y stages
//   - DATA_W / ITER_W : datapath word width and iteration index width
package cordic_pkg;

  localparam int DATA_W = 16;
  localparam int ITER_W = 5;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    RUN       = 3'd2,
    GAP       = 3'd3,
    WAIT_STEP = 3'd4
  } state_t;

endpackage

// File: rtl/cordic_pass_timer.sv
// RUN-cycle counter for one CORDIC pass.
//   clk, rst_n : system clock, async active-low reset
//   clear      : synchronous clear (wins over en)
//   en         : count one cycle
//   count      : cycles counted since the last clear
//   expired    : count has reached TIMEOUT-1
module cordic_pass_timer #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Iteration sequencer for the bit-serial CORDIC datapath.
//   clk, rst_n          : system clock, async active-low reset
//   go                  : start a full run from IDLE
//   step_mode, step     : pause after each iteration / advance one iteration
//   sign                : z register sign from the z stage (1 = negative)
//   zdone, xdone, ydone : per-stage end-of-pass flags
//   iter                : iteration index to all stages (0 = load initial values)
//   start               : shift/compare enable, held high for a whole pass
//   op_z, op_x, op_y    : adder controls (1 = subtract)
//   busy, done, err     : run in progress / run complete pulse / sticky timeout
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | iter=0, waiting for go
// SETUP     | iter=k, ops settled from sign, start still low
// RUN       | start high, waiting for all three stage done flags
// GAP       | start low so stages clear; advance k or finish
// WAIT_STEP | single-step pause, iter already shows the next k
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int N_ITER  = 16,
  parameter int TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              step_mode,
  input  logic              step,
  input  logic              sign,
  input  logic              zdone,
  input  logic              xdone,
  input  logic              ydone,
  output logic [ITER_W-1:0] iter,
  output logic              start,
  output logic              op_z,
  output logic              op_x,
  output logic              op_y,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [ITER_W-1:0] iter_nxt;
  logic              start_nxt;
  logic              op_z_nxt, op_x_nxt, op_y_nxt;
  logic              busy_nxt, done_nxt, err_nxt;
  logic              d_neg, d_neg_nxt;
  logic              load_ops;

  logic              in_run;
  logic [CNT_W-1:0]  run_cnt;
  logic              run_expired;
  logic              pass_done;

  assign in_run = (state == RUN);

  cordic_pass_timer #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_pass_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!in_run),
    .en     (in_run),
    .count  (run_cnt),
    .expired(run_expired)
  );

  // Flags left high from the previous pass are ignored in the first RUN cycle.
  assign pass_done = zdone & xdone & ydone & (run_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      iter  <= '0;
      start <= 1'b0;
      op_z  <= OP_ADD;
      op_x  <= OP_ADD;
      op_y  <= OP_ADD;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      d_neg <= 1'b0;
    end else begin
      state <= state_nxt;
      iter  <= iter_nxt;
      start <= start_nxt;
      op_z  <= op_z_nxt;
      op_x  <= op_x_nxt;
      op_y  <= op_y_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
      d_neg <= d_neg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    iter_nxt  = iter;
    start_nxt = start;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = err;
    load_ops  = 1'b0;

    case (state)
      IDLE: begin
        iter_nxt  = '0;
        start_nxt = 1'b0;
        if (go) begin
          busy_nxt  = 1'b1;
          err_nxt   = 1'b0;
          iter_nxt  = ITER_W'(1);
          load_ops  = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        start_nxt = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (pass_done) begin
          start_nxt = 1'b0;
          state_nxt = GAP;
        end else if (run_expired) begin
          start_nxt = 1'b0;
          err_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          iter_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      GAP: begin
        if (iter == ITER_W'(N_ITER)) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          iter_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          iter_nxt = iter + ITER_W'(1);
          if (step_mode) begin
            state_nxt = WAIT_STEP;
          end else begin
            load_ops  = 1'b1;
            state_nxt = SETUP;
          end
        end
      end
      WAIT_STEP: begin
        if (step) begin
          load_ops  = 1'b1;
          state_nxt = SETUP;
        end
      end
      default: begin
        iter_nxt  = '0;
        start_nxt = 1'b0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase

    // Ops are captured on SETUP entry so they settle a full cycle before start
    // rises and cannot move again until the next SETUP.
    d_neg_nxt = load_ops ? sign : d_neg;
    op_z_nxt  = d_neg_nxt ? OP_ADD : OP_SUB;
    op_x_nxt  = d_neg_nxt ? OP_ADD : OP_SUB;
    op_y_nxt  = d_neg_nxt ? OP_SUB : OP_ADD;
  end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
module tb_cordic_seq_ctrl;
  localparam int N  = 16;
  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic       sign = 1'b0, zdone = 1'b0, xdone = 1'b0, ydone = 1'b0;
  logic [4:0] iter;
  logic       start, op_z, op_x, op_y, busy, done, err;

  always #5 clk = ~clk;

  cordic_seq_ctrl #(.N_ITER(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .step_mode(step_mode), .step(step),
    .sign(sign), .zdone(zdone), .xdone(xdone), .ydone(ydone),
    .iter(iter), .start(start), .op_z(op_z), .op_x(op_x), .op_y(op_y),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct { int it; int ops; } pass_t;
  typedef struct { int kind; int cyc; } end_t;   // kind 0 = done, 1 = timeout
  pass_t exp_pass[$];
  end_t  exp_end[$];

  int n_chk = 0, n_err = 0;
  int cyc = 0, t_go = 0, busy_tot = 0, b_go = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  always @(posedge clk) cyc++;

  // Stage model: each done flag rises at a configured RUN cycle; the z sign
  // for the next pass comes from the run's sign pattern.
  int          dz = 17, dx = 17, dy = 17;
  bit          hold_y = 0;
  logic [17:0] pat = '0;
  int          run_id = 0, seen_id = 0, pass_cnt = 0, rc = 0;

  always @(posedge clk) begin
    #1;
    if (run_id != seen_id) begin
      seen_id = run_id;
      pass_cnt = 0;
    end
    if (start) rc++;
    else begin
      if (rc > 0) pass_cnt++;
      rc = 0;
    end
    sign  = pat[(pass_cnt + 1 > 17) ? 17 : pass_cnt + 1];
    zdone = start && rc >= dz;
    xdone = start && rc >= dx;
    ydone = start && !hold_y && rc >= dy;
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  logic  prev_start = 1'b0, prev_err = 1'b0;
  int    held_ops = 0;
  bit    ops_chg = 0;
  pass_t p;
  end_t  e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
      prev_err   = 1'b0;
    end else begin
      if (busy) busy_tot++;
      if (start && !prev_start) begin
        chk("pass_expected", int'(exp_pass.size() > 0), 1);
        if (exp_pass.size() > 0) begin
          p = exp_pass.pop_front();
          chk("pass_iter", int'(iter), p.it);
          chk("pass_ops", int'({op_z, op_x, op_y}), p.ops);
        end
        held_ops = int'({op_z, op_x, op_y});
        ops_chg  = 0;
      end else if (start && prev_start) begin
        if (int'({op_z, op_x, op_y}) != held_ops) ops_chg = 1;
      end
      if (!start && prev_start) chk("ops_stable_in_run", int'(ops_chg), 0);
      if (done) begin
        chk("done_expected", int'(exp_end.size() > 0), 1);
        if (exp_end.size() > 0) begin
          e = exp_end.pop_front();
          chk("end_kind_done", 0, e.kind);
          if (e.cyc >= 0) begin
            chk("done_latency", cyc - t_go, e.cyc);
            chk("busy_cycles", busy_tot - b_go, e.cyc);
          end
          chk("busy_at_done", int'(busy), 0);
          chk("passes_left_at_done", exp_pass.size(), 0);
          chk("iter_at_done", int'(iter), 0);
        end
      end
      if (err && !prev_err) begin
        chk("timeout_expected", int'(exp_end.size() > 0), 1);
        if (exp_end.size() > 0) begin
          e = exp_end.pop_front();
          chk("end_kind_timeout", 1, e.kind);
          chk("timeout_latency", cyc - t_go, e.cyc);
          chk("busy_cycles_timeout", busy_tot - b_go, e.cyc);
          chk("busy_at_timeout", int'(busy), 0);
          chk("no_done_at_timeout", int'(done), 0);
        end
      end
      prev_start = start;
      prev_err   = err;
    end
  end

  task automatic pulse_go(input bit with_step);
    @(posedge clk); #1;
    go = 1'b1;
    step = with_step;
    @(posedge clk); #1;
    go = 1'b0;
    step = 1'b0;
  endtask

  task automatic pulse_step();
    @(posedge clk); #1;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
  endtask

  // Reference: every pass k in 1..N shows iter=k and ops from the sign fed
  // for that pass; a pass lasts SETUP + max(latest done, 2) RUN cycles + GAP.
  task automatic do_run(input logic [17:0] sp, input int a, input int b, input int c,
                        input bit hy, input bit sm, input bit go_step);
    pass_t np;
    end_t  ne;
    int    npass;
    pat = sp; dz = a; dx = b; dy = c; hold_y = hy; step_mode = sm;
    run_id++;
    repeat (2) @(posedge clk);
    npass = hy ? 1 : N;
    for (int k = 1; k <= npass; k++) begin
      np.it  = k;
      np.ops = sp[k] ? 3'b001 : 3'b110;
      exp_pass.push_back(np);
    end
    if (hy) begin
      ne.kind = 1; ne.cyc = 1 + TO;
    end else begin
      ne.kind = 0; ne.cyc = sm ? -1 : N * (2 + max2(2, max2(a, max2(b, c))));
    end
    exp_end.push_back(ne);
    pulse_go(go_step);
    t_go = cyc;
    b_go = busy_tot;
    chk("go_busy", int'(busy), 1);
    chk("go_clears_err", int'(err), 0);
    chk("go_iter", int'(iter), 1);
    chk("go_start_low", int'(start), 0);
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget && exp_end.size() != 0; i++) @(posedge clk);
    chk("run_finished_in_budget", exp_end.size(), 0);
    exp_end.delete();
    exp_pass.delete();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    #3;
    chk("rst_iter", int'(iter), 0);
    chk("rst_start", int'(start), 0);
    chk("rst_ops", int'({op_z, op_x, op_y}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    #19 rst_n = 1'b1;

    // Normal run, sign always 0; a go and a step while busy are ignored.
    do_run(18'h0, 17, 17, 17, 0, 0, 0);
    repeat (50) @(posedge clk);
    pulse_go(0);
    pulse_step();
    wait_end(400);

    // Sign negative on odd iterations.
    do_run(18'h2AAAA, 17, 17, 17, 0, 0, 0);
    wait_end(400);

    // Random signs and done timing; go and step together in IDLE.
    do_run(18'($urandom()), int'($urandom_range(1, 30)), int'($urandom_range(1, 30)),
           int'($urandom_range(1, 30)), 0, 0, 1);
    wait_end(700);

    // Stale done flags, high from the first RUN cycle.
    do_run(18'($urandom()), 1, 1, 1, 0, 0, 0);
    wait_end(200);

    // Skewed done flags.
    do_run(18'($urandom()), 17, 20, 25, 0, 0, 0);
    wait_end(600);

    // Single-step mode.
    do_run(18'($urandom()), 17, 17, 17, 0, 1, 0);
    repeat (60) @(posedge clk); #1;
    chk("step_wait_iter", int'(iter), 2);
    chk("step_wait_start", int'(start), 0);
    chk("step_wait_busy", int'(busy), 1);
    for (int s = 0; s < N - 1; s++) begin
      pulse_step();
      repeat (24) @(posedge clk);
    end
    wait_end(100);
    step_mode = 1'b0;

    // Timeout: ydone never rises.
    do_run(18'($urandom()), 17, 17, 17, 1, 0, 0);
    wait_end(100);
    #1;
    chk("err_sticky", int'(err), 1);
    chk("busy_after_timeout", int'(busy), 0);

    // Recovery after timeout.
    do_run(18'($urandom()), 17, 17, 17, 0, 0, 0);
    wait_end(400);

    // Reset in the middle of iteration 7.
    do_run(18'($urandom()), 17, 17, 17, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      if (iter == 5'd7 && start) found = 1;
    end
    chk("reached_iter7_run", int'(found), 1);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_iter", int'(iter), 0);
    chk("midrst_start", int'(start), 0);
    chk("midrst_busy", int'(busy), 0);
    exp_pass.delete();
    exp_end.delete();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    do_run(18'($urandom()), 17, 17, 17, 0, 0, 0);
    repeat (30) @(posedge clk);
    pulse_go(0);
    wait_end(400);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
